// File: rtl/sparse_pkg.sv
// Shared types and field layout for the dense-to-sparse encoder.
package sparse_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int WORD_LENGTH = 8;
  localparam int ENTRY_W     = 3 * WORD_LENGTH;

  // Entry layout is {value, col, row}, row in the least-significant field.
  localparam int VALUE_SLOT = 2;
  localparam int COL_SLOT   = 1;
  localparam int ROW_SLOT   = 0;

  function automatic int entry_w(input int wl);
    return 3 * wl;
  endfunction

  function automatic int field_lsb(input int wl, input int slot);
    return slot * wl;
  endfunction

endpackage

// File: rtl/sparse_fifo.sv
// Small synchronous FIFO for encoder triplets; the head is read combinationally so a
// push into an empty FIFO is presented on the following cycle.
module sparse_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Stale storage is masked so an empty FIFO always presents zeros.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sparse_encoder.sv
// Converts a raster-order dense pixel stream into (value, col, row) triplets for
// nonzero pixels and reports the nonzero count of each completed frame.
module sparse_encoder
  import sparse_pkg::*;
#(
  parameter int word_length = 8,
  parameter int image_size  = 28,
  parameter int count_width = 16,
  parameter int fifo_depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [word_length-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [word_length-1:0] out_value,
  output logic [word_length-1:0] out_col,
  output logic [word_length-1:0] out_row,
  output logic [count_width-1:0] valid_num,
  output logic                   frame_done
);

  localparam int EW      = entry_w(word_length);
  localparam int VAL_LSB = field_lsb(word_length, VALUE_SLOT);
  localparam int COL_LSB = field_lsb(word_length, COL_SLOT);
  localparam int ROW_LSB = field_lsb(word_length, ROW_SLOT);
  localparam logic [word_length-1:0] LAST_IDX = word_length'(image_size - 1);

  state_e                 state_q, state_d;
  logic [word_length-1:0] col_q, row_q;
  logic [count_width-1:0] nz_cnt_q, valid_num_q;
  logic                   rdy_en_q;
  logic                   fifo_full, fifo_empty;
  logic [EW-1:0]          fifo_head;
  logic                   accept, nz_push, last_px, pop;

  assign accept  = in_valid && in_ready;
  assign nz_push = accept && (|in_pixel);
  assign last_px = accept && (col_q == LAST_IDX) && (row_q == LAST_IDX);
  assign pop     = out_valid && out_ready;

  sparse_fifo #(
    .WIDTH (EW),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (nz_push),
    .push_data_i ({in_pixel, col_q, row_q}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (last_px) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // rdy_en_q holds in_ready low through reset and releases it one edge later.
  always_comb begin
    in_ready   = rdy_en_q && (state_q == ST_RUN) && !fifo_full;
    frame_done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      nz_cnt_q    <= '0;
      valid_num_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (state_q == ST_DONE) begin
        col_q       <= '0;
        row_q       <= '0;
        nz_cnt_q    <= '0;
        valid_num_q <= nz_cnt_q;
      end else begin
        if (accept) begin
          if (col_q == LAST_IDX) begin
            col_q <= '0;
            row_q <= row_q + word_length'(1);
          end else begin
            col_q <= col_q + word_length'(1);
          end
        end
        if (nz_push) nz_cnt_q <= nz_cnt_q + count_width'(1);
      end
    end
  end

  assign out_valid = !fifo_empty;
  assign out_value = fifo_head[VAL_LSB +: word_length];
  assign out_col   = fifo_head[COL_LSB +: word_length];
  assign out_row   = fifo_head[ROW_LSB +: word_length];
  assign valid_num = valid_num_q;

endmodule

// File: tb/tb_sparse_encoder.sv
// Scoreboard bench for sparse_encoder: expected triplets are queued as pixels are
// accepted and compared as the encoder hands them out.
module tb_sparse_encoder;

  localparam int WL   = 8;
  localparam int IS   = 28;
  localparam int CW   = 16;
  localparam int FD   = 4;
  localparam int NPIX = IS * IS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WL-1:0] in_pixel = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WL-1:0] out_value, out_col, out_row;
  logic [CW-1:0] valid_num;
  logic          frame_done;

  always #5 clk = ~clk;

  sparse_encoder #(
    .word_length (WL),
    .image_size  (IS),
    .count_width (CW),
    .fifo_depth  (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_col    (out_col),
    .out_row    (out_row),
    .valid_num  (valid_num),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt = 0;
  int done_count = 0;
  int done_cyc = 0;
  int beats = 0;
  int first_valid_cyc = -1;
  int last_push_cyc = 0;
  int first_acc_cyc = 0;
  int stall_cnt = 0;
  int first_stall_idx = -1;

  logic [3*WL-1:0] exp_q [$];
  logic [3*WL-1:0] hold_val, got, expv;
  logic            hold_pending = 1'b0;
  logic            prev_valid = 1'b0;
  logic [WL-1:0]   last_col = '0, last_row = '0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Output monitor: scoreboard pops, stability under backpressure, done pulses.
  always @(negedge clk) begin
    if (rst) begin
      got = {out_value, out_col, out_row};
      if (hold_pending) begin
        n_checks++;
        if (!out_valid || got !== hold_val) begin
          n_errors++;
          $display("FAIL hold_stable: got valid=%0b %h, expected valid=1 %h", out_valid, got, hold_val);
        end
      end
      if (out_valid) begin
        if (!prev_valid) first_valid_cyc = cyc_cnt;
        if (out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL beat_unexpected: got %h, expected no beat", got);
          end else begin
            expv = exp_q.pop_front();
            if (got !== expv) begin
              n_errors++;
              $display("FAIL beat_value: got %h, expected %h", got, expv);
            end
          end
          beats++;
          last_col = out_col;
          last_row = out_row;
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          hold_val = got;
        end
      end else begin
        hold_pending = 1'b0;
      end
      prev_valid = out_valid;
      if (frame_done) begin
        done_count++;
        done_cyc = cyc_cnt;
      end
    end else begin
      hold_pending = 1'b0;
      prev_valid = 1'b0;
    end
  end

  function automatic logic [WL-1:0] pix(input int mode, input int idx);
    case (mode)
      1: return (idx == 3 * IS + 5) ? 8'h7F : 8'h00;
      2: return 8'h01;
      3: if ((idx >= 1 && idx <= 4) || (idx >= 35 && idx % 7 == 0))
           return 8'((idx * 37) % 255 + 1);
         else
           return 8'h00;
      4: return (idx == NPIX - 1) ? 8'hA5 : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic drive_frame(input int mode, input int npix);
    int idx = 0;
    int t = 0;
    logic [WL-1:0] p;
    stall_cnt = 0;
    first_stall_idx = -1;
    while (idx < npix && t < 20000) begin
      p = pix(mode, idx);
      in_valid = 1'b1;
      in_pixel = p;
      @(negedge clk);
      if (in_ready) begin
        if (idx == 0) first_acc_cyc = cyc_cnt;
        if (p != 0) begin
          exp_q.push_back({p, 8'(idx % IS), 8'(idx / IS)});
          last_push_cyc = cyc_cnt;
        end
        idx++;
      end else begin
        stall_cnt++;
        if (first_stall_idx < 0) first_stall_idx = idx;
      end
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    in_pixel = '0;
    n_checks++;
    if (idx != npix) begin
      n_errors++;
      $display("FAIL drive_timeout: accepted %0d, expected %0d", idx, npix);
    end
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_count == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (done_count == d0) begin
      n_errors++;
      $display("FAIL done_timeout: got no frame_done, expected one within 3000 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got in_ready=%b out_valid=%b frame_done=%b, expected 0 0 0",
               in_ready, out_valid, frame_done);
    end
    n_checks++;
    if ({out_value, out_col, out_row} !== 24'h0 || valid_num !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_data: got %h valid_num=%0d, expected 0 and 0",
               {out_value, out_col, out_row}, valid_num);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_frame();
    int d0 = done_count;
    int b0 = beats;
    out_ready = 1'b1;
    drive_frame(0, NPIX);
    wait_done(d0);
    n_checks++;
    if (done_count !== d0 + 1) begin
      n_errors++;
      $display("FAIL zero_done_pulses: got %0d, expected 1", done_count - d0);
    end
    n_checks++;
    if (done_cyc - first_acc_cyc !== 785) begin
      n_errors++;
      $display("FAIL zero_done_latency: got %0d, expected 785", done_cyc - first_acc_cyc);
    end
    n_checks++;
    if (beats !== b0) begin
      n_errors++;
      $display("FAIL zero_beats: got %0d, expected 0", beats - b0);
    end
    n_checks++;
    if (valid_num !== 16'd0) begin
      n_errors++;
      $display("FAIL zero_valid_num: got %0d, expected 0", valid_num);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int d0 = done_count;
    int b0 = beats;
    out_ready = 1'b1;
    first_valid_cyc = -1;
    drive_frame(1, NPIX);
    wait_done(d0);
    n_checks++;
    if (beats !== b0 + 1) begin
      n_errors++;
      $display("FAIL single_beats: got %0d, expected 1", beats - b0);
    end
    n_checks++;
    if (first_valid_cyc - last_push_cyc !== 1) begin
      n_errors++;
      $display("FAIL single_latency: got %0d, expected 1", first_valid_cyc - last_push_cyc);
    end
    n_checks++;
    if (valid_num !== 16'd1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL single_valid_num: got %0d (pending %0d), expected 1 (pending 0)",
               valid_num, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_dense();
    int d0 = done_count;
    int b0 = beats;
    out_ready = 1'b1;
    drive_frame(2, NPIX);
    wait_done(d0);
    n_checks++;
    if (stall_cnt !== 0) begin
      n_errors++;
      $display("FAIL dense_in_ready: got %0d stalls, expected 0", stall_cnt);
    end
    n_checks++;
    if (beats !== b0 + NPIX) begin
      n_errors++;
      $display("FAIL dense_beats: got %0d, expected %0d", beats - b0, NPIX);
    end
    n_checks++;
    if (last_col !== 8'd27 || last_row !== 8'd27) begin
      n_errors++;
      $display("FAIL dense_last_beat: got col=%0d row=%0d, expected 27 27", last_col, last_row);
    end
    n_checks++;
    if (valid_num !== 16'd784 || done_count !== d0 + 1) begin
      n_errors++;
      $display("FAIL dense_valid_num: got %0d pulses=%0d, expected 784 pulses=1",
               valid_num, done_count - d0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int d0 = done_count;
    int b0 = beats;
    out_ready = 1'b0;
    fork
      drive_frame(3, NPIX);
      begin
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_done(d0);
    n_checks++;
    if (first_stall_idx !== 5) begin
      n_errors++;
      $display("FAIL bp_first_stall: got pixel %0d, expected 5", first_stall_idx);
    end
    n_checks++;
    if (beats !== b0 + 111 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL bp_beats: got %0d (pending %0d), expected 111 (pending 0)",
               beats - b0, exp_q.size());
    end
    n_checks++;
    if (valid_num !== 16'd111) begin
      n_errors++;
      $display("FAIL bp_valid_num: got %0d, expected 111", valid_num);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain();
    int d0 = done_count;
    int b0 = beats;
    out_ready = 1'b0;
    drive_frame(4, NPIX);
    repeat (10) @(negedge clk);
    n_checks++;
    if (done_count !== d0 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_withheld: got pulses=%0d out_valid=%b, expected 0 and 1",
               done_count - d0, out_valid);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(d0);
    n_checks++;
    if (done_count !== d0 + 1 || beats !== b0 + 1) begin
      n_errors++;
      $display("FAIL drain_release: got pulses=%0d beats=%0d, expected 1 and 1",
               done_count - d0, beats - b0);
    end
    n_checks++;
    if (valid_num !== 16'd1) begin
      n_errors++;
      $display("FAIL drain_valid_num: got %0d, expected 1", valid_num);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int d0;
    int b0;
    out_ready = 1'b1;
    drive_frame(2, 300);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_precond: got out_valid=%b, expected 1", out_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || valid_num !== 16'd0) begin
      n_errors++;
      $display("FAIL midrst_async: got out_valid=%b in_ready=%b valid_num=%0d, expected 0 0 0",
               out_valid, in_ready, valid_num);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    d0 = done_count;
    b0 = beats;
    drive_frame(1, NPIX);
    wait_done(d0);
    n_checks++;
    if (beats !== b0 + 1 || valid_num !== 16'd1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL midrst_next_frame: got beats=%0d valid_num=%0d, expected 1 and 1",
               beats - b0, valid_num);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_single();
    test_dense();
    test_backpressure();
    test_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before 2 ms");
    $fatal(1);
  end

endmodule
